// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the unified-memory arbiter: FSM states, port IDs
// and the access-counter width helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // CNT_W = $clog2(MEM_LATENCY+1), never narrower than one bit.
    function automatic int cnt_width(input int mem_latency);
        int w;
        w = $clog2(mem_latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker between the CPU and debug ports,
// with a debug lock that keeps the grant on D once D has won.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic req_c_i,
    input  logic req_d_i,
    input  logic last_gnt_i,
    input  logic d_lock_i,
    output logic gnt_valid_o,
    output logic gnt_port_o
);

    always_comb begin
        gnt_valid_o = req_c_i | req_d_i;
        gnt_port_o  = PORT_C;
        if (req_c_i && req_d_i) begin
            // Lock only holds D if D already owned the previous grant.
            if (last_gnt_i == PORT_C) begin
                gnt_port_o = PORT_D;
            end else begin
                gnt_port_o = d_lock_i ? PORT_D : PORT_C;
            end
        end else if (req_d_i) begin
            gnt_port_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between the CPU (C) and debug (D)
// requesters, sequencing each access IDLE -> ACCESS -> RESP.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_e            state_o
);

    localparam int CNT_W = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt_valid;
    logic              gnt_port;
    logic [ADDR_W-1:0] sel_addr;

    rr_arb2 u_rr_arb2 (
        .req_c_i     (c_req),
        .req_d_i     (d_req),
        .last_gnt_i  (last_gnt_q),
        .d_lock_i    (d_lock),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    assign sel_addr = (gnt_port == PORT_D) ? d_addr : c_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= PORT_C;
            last_gnt_q <= PORT_D;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d    = gnt_port;
                    last_gnt_d = gnt_port;
                    we_d       = (gnt_port == PORT_D) ? d_we : c_we;
                    addr_d     = sel_addr;
                    wdata_d    = (gnt_port == PORT_D) ? d_wdata : c_wdata;
                    if (sel_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with err, never touch memory.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign c_ready   = (state_q == RESP) && (owner_q == PORT_C);
    assign d_ready   = (state_q == RESP) && (owner_q == PORT_D);
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    // Memory outputs read as zero outside ACCESS so the bus is quiet when idle.
    assign mem_addr  = (state_q == ACCESS) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 instance for the main scenarios and a
// LAT=3 instance for the reset-during-access case.
module tb_mem_arbiter;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_ready, d_ready, err, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    state_e      state;
    logic        c_ready3, d_ready3, err3, mem_en3, mem_we3;
    logic [31:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    state_e      state3;

    logic [31:0] mem  [16];
    logic [31:0] mem3 [16];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_ready(d_ready), .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_o(state)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_ready(d_ready3), .rdata(rdata3), .err(err3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .state_o(state3)
    );

    // Memory models: synchronous write, combinational read.
    assign mem_rdata  = mem[mem_addr[3:0]];
    assign mem_rdata3 = mem3[mem_addr3[3:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_en3 && mem_we3) mem3[mem_addr3[3:0]] <= mem_wdata3;
    end

    task automatic wait_ready(output bit got_c, output bit got_d, output logic [31:0] rd,
                              output logic e, output int cycles, output int en_cycles,
                              output int we_cycles);
        bit done;
        got_c = 0; got_d = 0; rd = '0; e = 1'b0;
        cycles = 0; en_cycles = 0; we_cycles = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (mem_en) en_cycles++;
            if (mem_we) we_cycles++;
            if (c_ready || d_ready) begin
                got_c = c_ready; got_d = d_ready; rd = rdata; e = err; done = 1;
            end
        end
        if (!done) cycles = -1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; rst3 = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({c_ready, d_ready, err, mem_en, mem_we} !== 5'b0 || rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b%b err=%b en=%b we=%b rdata=%h addr=%h state=%0d, expected all zero/IDLE",
                     c_ready, d_ready, err, mem_en, mem_we, rdata, mem_addr, state);
        end
    endtask

    task automatic test_c_read();
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h8;
        @(negedge clk);
        tests_run++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h2) begin
            tests_failed++;
            $display("FAIL c_read_access: got en=%b we=%b addr=%h, expected en=1 we=0 addr=00000002", mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (c_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL c_read_latency: got c_ready=%b two edges after request, expected 1", c_ready);
        end
        tests_run++;
        if (rdata !== 32'h00208133 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL c_read_data: got rdata=%h d_ready=%b, expected 00208133 and 0", rdata, d_ready);
        end
        c_req = 0;
        @(negedge clk);
        tests_run++;
        if (c_ready !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL c_read_clear: got c_ready=%b rdata=%h, expected 0 and 0", c_ready, rdata);
        end
    endtask

    task automatic test_d_write_c_read();
        bit gc, gd; logic [31:0] rd; logic e; int cyc, en_c, we_c;
        d_req = 1; d_we = 1; d_addr = 32'h4; d_wdata = 32'hDEADBEEF;
        wait_ready(gc, gd, rd, e, cyc, en_c, we_c);
        d_req = 0; d_we = 0;
        tests_run++;
        if (gd !== 1'b1 || gc !== 1'b0 || we_c != 1 || cyc != 2) begin
            tests_failed++;
            $display("FAIL d_write: got d_rdy=%b c_rdy=%b we_cycles=%0d latency=%0d, expected 1 0 1 2", gd, gc, we_c, cyc);
        end
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h4;
        wait_ready(gc, gd, rd, e, cyc, en_c, we_c);
        c_req = 0;
        tests_run++;
        if (gc !== 1'b1 || rd !== 32'hDEADBEEF || we_c != 0) begin
            tests_failed++;
            $display("FAIL c_readback: got c_rdy=%b rdata=%h we_cycles=%0d, expected 1 deadbeef 0", gc, rd, we_c);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit gc, gd; logic [31:0] rd; logic e; int cyc, en_c, we_c;
        logic exp_d;
        apply_reset();
        c_req = 1; c_we = 0; c_addr = 32'h8;
        d_req = 1; d_we = 0; d_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            exp_d = (i % 2 == 1);
            wait_ready(gc, gd, rd, e, cyc, en_c, we_c);
            if (i == 3) begin c_req = 0; d_req = 0; end
            tests_run++;
            if (gd !== exp_d || gc !== !exp_d ||
                rd !== (exp_d ? 32'hDEADBEEF : 32'h00208133)) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got c_rdy=%b d_rdy=%b rdata=%h, expected d_rdy=%b", i, gc, gd, rd, exp_d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lock();
        bit gc, gd; logic [31:0] rd; logic e; int cyc, en_c, we_c;
        c_req = 1; c_we = 0; c_addr = 32'h8;
        d_req = 1; d_we = 0; d_addr = 32'h4; d_lock = 1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(gc, gd, rd, e, cyc, en_c, we_c);
            if (i == 2) d_lock = 0;
            if (i == 3) begin c_req = 0; d_req = 0; end
            tests_run++;
            if (gd !== (i < 3) || gc !== (i == 3)) begin
                tests_failed++;
                $display("FAIL lock_grant%0d: got c_rdy=%b d_rdy=%b, expected c_rdy=%b d_rdy=%b", i, gc, gd, i == 3, i < 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        bit gc, gd; logic [31:0] rd; logic e; int cyc, en_c, we_c;
        c_req = 1; c_we = 0; c_addr = 32'h6;
        wait_ready(gc, gd, rd, e, cyc, en_c, we_c);
        c_req = 0;
        tests_run++;
        if (gc !== 1'b1 || e !== 1'b1 || cyc != 1 || en_c != 0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL misaligned: got c_rdy=%b err=%b latency=%0d en_cycles=%0d rdata=%h, expected 1 1 1 0 0",
                     gc, e, cyc, en_c, rd);
        end
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0 || mem_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_clear: got err=%b mem_en=%b, expected 0 0", err, mem_en);
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc; bit seen;
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 32'hC; c_wdata = 32'h12345678;
        @(negedge clk); @(negedge clk);
        tests_run++;
        if (mem_en3 !== 1'b1 || mem_we3 !== 1'b1 || mem_addr3 !== 32'h3) begin
            tests_failed++;
            $display("FAIL lat3_access: got en=%b we=%b addr=%h, expected 1 1 00000003", mem_en3, mem_we3, mem_addr3);
        end
        rst3 = 1'b1;
        c_req = 0; c_we = 0;
        #1;
        tests_run++;
        if (mem_en3 !== 1'b0 || mem_we3 !== 1'b0 || state3 !== IDLE) begin
            tests_failed++;
            $display("FAIL lat3_async_reset: got en=%b we=%b state=%0d, expected 0 0 IDLE", mem_en3, mem_we3, state3);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (c_ready3 || d_ready3) seen = 1;
        end
        rst3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (c_ready3 || d_ready3) seen = 1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_no_ready: got a ready pulse after reset, expected none");
        end
        c_req = 1; c_we = 0; c_addr = 32'h8;
        cyc = -1;
        for (int i = 1; i <= 20 && cyc < 0; i++) begin
            @(negedge clk);
            if (c_ready3) cyc = i;
        end
        c_req = 0;
        tests_run++;
        if (cyc != 4 || rdata3 !== 32'h00208133) begin
            tests_failed++;
            $display("FAIL lat3_read: got latency=%0d rdata=%h, expected 4 00208133", cyc, rdata3);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'h0;
            mem3[i] = 32'h0;
        end
        mem[2]  = 32'h00208133;
        mem3[2] = 32'h00208133;
        test_reset();
        test_c_read();
        test_d_write_c_read();
        test_round_robin();
        test_lock();
        test_misaligned();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
